// File: rtl/counter_range_updown_param_if.sv
// Control and status bundle for counter_range_updown_param.
// master drives the controls; slave is the counter itself.
interface counter_range_updown_param_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) ();
  logic              en_in;
  logic              load_en_in;
  logic [WIDTH-1:0]  d_in;
  logic              ahup_aldown;
  logic [STEP_W-1:0] step_in;
  logic [1:0]        mode_in;
  logic [WIDTH-1:0]  count_out;
  logic              dir_out;
  logic              tc_out;
  logic              load_err_out;

  modport master (
    output en_in, load_en_in, d_in, ahup_aldown, step_in, mode_in,
    input  count_out, dir_out, tc_out, load_err_out
  );

  modport slave (
    input  en_in, load_en_in, d_in, ahup_aldown, step_in, mode_in,
    output count_out, dir_out, tc_out, load_err_out
  );
endinterface

// File: rtl/counter_range_updown_param.sv
// Bounded up/down counter with run-time step, wrap/saturate/bounce end
// behaviour, clamped parallel load and registered terminal-count pulse.
module counter_range_updown_param #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MIN_VAL = 10,
  parameter int unsigned MAX_VAL = 40,
  parameter int unsigned STEP_W  = 4
) (
  input  logic clk,
  input  logic reset_al_in,
  counter_range_updown_param_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  localparam int unsigned      EXT_W = WIDTH + STEP_W + 1;
  localparam logic [WIDTH-1:0] MIN_L = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             bdir_q, bdir_d;
  logic             tc_q, tc_d;
  logic             err_q, err_d;

  mode_t            mode;
  logic             eff_up;
  logic [EXT_W-1:0] step_x, cnt_x, up_sum, dn_lim;

  assign mode   = mode_t'(bus.mode_in);
  assign eff_up = (mode == MODE_BOUNCE) ? bdir_q : bus.ahup_aldown;

  // Down bound is tested as count <= MIN + s so no signed intermediate is needed.
  assign step_x = EXT_W'(bus.step_in);
  assign cnt_x  = EXT_W'(count_q);
  assign up_sum = cnt_x + step_x;
  assign dn_lim = EXT_W'(MIN_L) + step_x;

  always_comb begin
    count_d = count_q;
    bdir_d  = bdir_q;
    tc_d    = 1'b0;
    err_d   = 1'b0;
    if (bus.load_en_in) begin
      bdir_d = bus.ahup_aldown;
      if (bus.d_in < MIN_L) begin
        count_d = MIN_L;
        err_d   = 1'b1;
      end else if (bus.d_in > MAX_L) begin
        count_d = MAX_L;
        err_d   = 1'b1;
      end else begin
        count_d = bus.d_in;
      end
    end else if (bus.en_in && (bus.step_in != '0)) begin
      if (eff_up) begin
        if (up_sum < EXT_W'(MAX_L)) begin
          count_d = up_sum[WIDTH-1:0];
        end else begin
          tc_d = 1'b1;
          case (mode)
            MODE_SAT:    count_d = MAX_L;
            MODE_BOUNCE: begin
              count_d = MAX_L;
              bdir_d  = 1'b0;
            end
            default:     count_d = (up_sum == EXT_W'(MAX_L)) ? MAX_L : MIN_L;
          endcase
        end
      end else begin
        if (cnt_x > dn_lim) begin
          count_d = count_q - WIDTH'(bus.step_in);
        end else begin
          tc_d = 1'b1;
          case (mode)
            MODE_SAT:    count_d = MIN_L;
            MODE_BOUNCE: begin
              count_d = MIN_L;
              bdir_d  = 1'b1;
            end
            default:     count_d = (cnt_x == dn_lim) ? MIN_L : MAX_L;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      count_q <= MIN_L;
      bdir_q  <= 1'b1;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      bdir_q  <= bdir_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
    end
  end

  assign bus.count_out    = count_q;
  assign bus.dir_out      = eff_up;
  assign bus.tc_out       = tc_q;
  assign bus.load_err_out = err_q;

endmodule

// File: tb/tb_counter_range_updown_param.sv
// Randomised and directed checks of counter_range_updown_param against an
// integer-arithmetic reference model.
module tb_counter_range_updown_param;
  localparam int WIDTH  = 8;
  localparam int MINV   = 10;
  localparam int MAXV   = 40;
  localparam int STEP_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  counter_range_updown_param_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  counter_range_updown_param #(
    .WIDTH(WIDTH), .MIN_VAL(MINV), .MAX_VAL(MAXV), .STEP_W(STEP_W)
  ) dut (
    .clk(clk), .reset_al_in(rst_n), .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain integer arithmetic on the documented rules.
  int m_cnt, m_dir, m_tc, m_err, m_nxt, m_d, m_up, m_s, m_mode;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = MINV; m_dir = 1; m_tc = 0; m_err = 0;
    end else begin
      m_tc = 0; m_err = 0;
      m_s = int'(bus.step_in);
      m_mode = int'(bus.mode_in);
      if (bus.load_en_in) begin
        m_d = int'(bus.d_in);
        m_err = (m_d < MINV || m_d > MAXV) ? 1 : 0;
        m_cnt = (m_d < MINV) ? MINV : (m_d > MAXV) ? MAXV : m_d;
        m_dir = int'(bus.ahup_aldown);
      end else if (bus.en_in && m_s != 0) begin
        m_up  = (m_mode == 2) ? m_dir : int'(bus.ahup_aldown);
        m_nxt = m_up ? m_cnt + m_s : m_cnt - m_s;
        if (m_up && m_nxt >= MAXV) begin
          m_tc = 1;
          if (m_mode == 2) m_dir = 0;
          m_cnt = (m_mode == 1 || m_mode == 2 || m_nxt == MAXV) ? MAXV : MINV;
        end else if (!m_up && m_nxt <= MINV) begin
          m_tc = 1;
          if (m_mode == 2) m_dir = 1;
          m_cnt = (m_mode == 1 || m_mode == 2 || m_nxt == MINV) ? MINV : MAXV;
        end else begin
          m_cnt = m_nxt;
        end
      end
    end
  end

  bit cmp_on = 0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("count", int'(bus.count_out), m_cnt);
      chk("tc", int'(bus.tc_out), m_tc);
      chk("load_err", int'(bus.load_err_out), m_err);
      chk("dir", int'(bus.dir_out), (int'(bus.mode_in) == 2) ? m_dir : int'(bus.ahup_aldown));
    end
  end

  // Apply one set of inputs, let one rising edge consume them, return at edge+2.
  task automatic cyc(input bit en, input bit ld, input int d, input bit up,
                     input int s, input int mode);
    bus.en_in       = en;
    bus.load_en_in  = ld;
    bus.d_in        = WIDTH'(d);
    bus.ahup_aldown = up;
    bus.step_in     = STEP_W'(s);
    bus.mode_in     = 2'(mode);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.en_in = 0; bus.load_en_in = 0; bus.d_in = '0;
    bus.ahup_aldown = 1; bus.step_in = '0; bus.mode_in = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_count", int'(bus.count_out), 10);
    chk("reset_tc", int'(bus.tc_out), 0);
    chk("reset_err", int'(bus.load_err_out), 0);
    rst_n = 1'b1;
    cmp_on = 1;

    // Wrap up by 1 from 10: reaches 40 after 30 more edges, then 10.
    for (int i = 1; i <= 30; i++) begin
      cyc(1, 0, 0, 1, 1, 0);
      chk("wrap_up_count", int'(bus.count_out), 10 + i);
      chk("wrap_up_tc", int'(bus.tc_out), (i == 30) ? 1 : 0);
    end
    cyc(1, 0, 0, 1, 1, 0);
    chk("wrap_up_rollover", int'(bus.count_out), 10);
    chk("wrap_up_rollover_tc", int'(bus.tc_out), 1);

    // Wrap down by 4 from 13.
    cyc(0, 1, 13, 0, 4, 0);
    chk("load13", int'(bus.count_out), 13);
    cyc(1, 0, 0, 0, 4, 0);
    chk("wrap_dn_cross", int'(bus.count_out), 40);
    chk("wrap_dn_cross_tc", int'(bus.tc_out), 1);
    cyc(1, 0, 0, 0, 4, 0);
    chk("wrap_dn_36", int'(bus.count_out), 36);
    cyc(1, 0, 0, 0, 4, 0);
    chk("wrap_dn_32", int'(bus.count_out), 32);
    chk("wrap_dn_32_tc", int'(bus.tc_out), 0);

    // Saturate up by 7 from 35.
    cyc(0, 1, 35, 1, 7, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1, 7, 1);
      chk("sat_count", int'(bus.count_out), 40);
      chk("sat_tc", int'(bus.tc_out), 1);
    end
    cyc(0, 0, 0, 1, 7, 1);
    chk("sat_hold", int'(bus.count_out), 40);
    chk("sat_hold_tc", int'(bus.tc_out), 0);

    // Bounce by 5 from 30, direction input toggled and ignored.
    cyc(0, 1, 30, 1, 5, 2);
    chk("bounce_load", int'(bus.count_out), 30);
    chk("bounce_dir0", int'(bus.dir_out), 1);
    cyc(1, 0, 0, 0, 5, 2);
    chk("bounce_35", int'(bus.count_out), 35);
    cyc(1, 0, 0, 1, 5, 2);
    chk("bounce_40", int'(bus.count_out), 40);
    chk("bounce_40_tc", int'(bus.tc_out), 1);
    chk("bounce_40_dir", int'(bus.dir_out), 0);
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 0, 0, i[0], 5, 2);
      chk("bounce_dn", int'(bus.count_out), 40 - 5 * i);
    end
    chk("bounce_10_tc", int'(bus.tc_out), 1);
    chk("bounce_10_dir", int'(bus.dir_out), 1);
    cyc(1, 0, 0, 0, 5, 2);
    chk("bounce_15", int'(bus.count_out), 15);
    chk("bounce_15_tc", int'(bus.tc_out), 0);

    // Clamped loads.
    cyc(0, 1, 3, 1, 0, 0);
    chk("clamp_lo", int'(bus.count_out), 10);
    chk("clamp_lo_err", int'(bus.load_err_out), 1);
    cyc(0, 1, 200, 1, 0, 0);
    chk("clamp_hi", int'(bus.count_out), 40);
    chk("clamp_hi_err", int'(bus.load_err_out), 1);
    cyc(0, 1, 25, 1, 0, 0);
    chk("load25", int'(bus.count_out), 25);
    chk("load25_err", int'(bus.load_err_out), 0);
    cyc(1, 1, 20, 1, 3, 0);
    chk("load_over_count", int'(bus.count_out), 20);
    cyc(0, 0, 0, 1, 3, 0);
    chk("err_clears", int'(bus.load_err_out), 0);

    // Asynchronous reset between edges at 27.
    cyc(0, 1, 27, 1, 1, 0);
    chk("pre_reset", int'(bus.count_out), 27);
    bus.load_en_in = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_count", int'(bus.count_out), 10);
    chk("async_reset_tc", int'(bus.tc_out), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(1, 0, 0, 1, 1, 0);
    chk("post_reset_11", int'(bus.count_out), 11);

    // Randomised phase.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0),
          int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 150) == 0) begin
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
      end
    end

    cmp_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule
